// File: rtl/piece_controller_pkg.sv
// Shared types for the falling-piece controller.
//   piece_type_e  : tetromino encoding (I,O,T,S,Z,J,L = 0..6)
//   block_color   : colour of a cell as seen by the renderer
//   pc_state_e    : controller FSM states
//   type_color()  : colour assigned to each piece type
//   GRAVITY_FRAMES_DEFAULT, SPAWN_X_DEFAULT : controller parameter defaults
package piece_controller_pkg;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_type_e;

  typedef enum logic [3:0] {
    EMPTY  = 4'd0,
    CYAN   = 4'd1,
    YELLOW = 4'd2,
    PURPLE = 4'd3,
    GREEN  = 4'd4,
    RED    = 4'd5,
    BLUE   = 4'd6,
    ORANGE = 4'd7
  } block_color;

  typedef enum logic [2:0] {
    WAIT_START = 3'd0,
    SPAWN      = 3'd1,
    FALL       = 3'd2,
    LOCK       = 3'd3,
    OVER       = 3'd4
  } pc_state_e;

  localparam int         GRAVITY_FRAMES_DEFAULT = 30;
  localparam logic [4:0] SPAWN_X_DEFAULT        = 5'd3;

  function automatic block_color type_color(input logic [2:0] t);
    block_color c;
    case (t)
      PIECE_I: c = CYAN;
      PIECE_O: c = YELLOW;
      PIECE_T: c = PURPLE;
      PIECE_S: c = GREEN;
      PIECE_Z: c = RED;
      PIECE_J: c = BLUE;
      PIECE_L: c = ORANGE;
      default: c = EMPTY;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/piece_controller_tetromino_shape.sv
// SRS orientation table: cell offsets of a tetromino inside its 4x4 box.
//   piece_type in 3  piece type (0..6 = I,O,T,S,Z,J,L)
//   rot        in 2  orientation 0..3 (clockwise)
//   x_off      out 8 x offsets, cell0..cell3 as [7:6],[5:4],[3:2],[1:0]
//   y_off      out 8 y offsets, same packing (y grows downward)
module tetromino_shape
  import piece_controller_pkg::*;
(
  input  logic [2:0] piece_type,
  input  logic [1:0] rot,
  output logic [7:0] x_off,
  output logic [7:0] y_off
);

  // Pack four (x,y) pairs as {x0,x1,x2,x3,y0,y1,y2,y3}.
  function automatic logic [15:0] cells(input logic [1:0] x0, input logic [1:0] y0,
                                        input logic [1:0] x1, input logic [1:0] y1,
                                        input logic [1:0] x2, input logic [1:0] y2,
                                        input logic [1:0] x3, input logic [1:0] y3);
    return {x0, x1, x2, x3, y0, y1, y2, y3};
  endfunction

  logic [15:0] tbl;

  always_comb begin
    tbl = cells(2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1);  // O, and unused type 7
    case ({piece_type, rot})
      {PIECE_I, 2'd0}: tbl = cells(2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd3, 2'd1);
      {PIECE_I, 2'd1}: tbl = cells(2'd2, 2'd0, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3);
      {PIECE_I, 2'd2}: tbl = cells(2'd0, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2);
      {PIECE_I, 2'd3}: tbl = cells(2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd3);
      {PIECE_T, 2'd0}: tbl = cells(2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1);
      {PIECE_T, 2'd1}: tbl = cells(2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2);
      {PIECE_T, 2'd2}: tbl = cells(2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2);
      {PIECE_T, 2'd3}: tbl = cells(2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2);
      {PIECE_S, 2'd0}: tbl = cells(2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1);
      {PIECE_S, 2'd1}: tbl = cells(2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2);
      {PIECE_S, 2'd2}: tbl = cells(2'd1, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd2);
      {PIECE_S, 2'd3}: tbl = cells(2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2);
      {PIECE_Z, 2'd0}: tbl = cells(2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1);
      {PIECE_Z, 2'd1}: tbl = cells(2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2);
      {PIECE_Z, 2'd2}: tbl = cells(2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2);
      {PIECE_Z, 2'd3}: tbl = cells(2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2);
      {PIECE_J, 2'd0}: tbl = cells(2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1);
      {PIECE_J, 2'd1}: tbl = cells(2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2);
      {PIECE_J, 2'd2}: tbl = cells(2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2);
      {PIECE_J, 2'd3}: tbl = cells(2'd1, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 2'd2);
      {PIECE_L, 2'd0}: tbl = cells(2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1);
      {PIECE_L, 2'd1}: tbl = cells(2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2);
      {PIECE_L, 2'd2}: tbl = cells(2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd0, 2'd2);
      {PIECE_L, 2'd3}: tbl = cells(2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2);
      default: ;
    endcase
  end

  assign x_off = tbl[15:8];
  assign y_off = tbl[7:0];

endmodule

// File: rtl/piece_controller.sv
// Falling-piece controller: spawns, moves, rotates, drops and locks the
// active tetromino, and publishes its cells plus every candidate move so the
// board can judge legality (can_move) one frame ahead.
//   Clk, Reset                 clock, asynchronous active-high reset
//   frame_clk_rising_edge      one-Clk pulse per video frame
//   key_*                      level key states
//   can_move[4:0]              legal: left, right, rot right, rot left, down
//   BOARD_BUSY, rand_piece     board clearing rows; next piece select
//   x_block, y_block           current cells, cell0..cell3 = [19:15]..[4:0]
//   save_xblock, save_yblock   cells as drawn on the previous Clk
//   x_/y_move_*, x_/y_rotate_* candidate cells for each single change
//   get_new_block, block, game_over  spawn pulse, piece colour, end of game
module piece_controller
  import piece_controller_pkg::*;
#(
  parameter int         GRAVITY_FRAMES = GRAVITY_FRAMES_DEFAULT,
  parameter logic [4:0] SPAWN_X        = SPAWN_X_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk_rising_edge,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_rot_l,
  input  logic        key_rot_r,
  input  logic        key_down,
  input  logic [4:0]  can_move,
  input  logic        BOARD_BUSY,
  input  logic [2:0]  rand_piece,
  output logic [19:0] x_block,
  output logic [19:0] y_block,
  output logic [19:0] save_xblock,
  output logic [19:0] save_yblock,
  output logic [19:0] x_move_left,
  output logic [19:0] y_move_left,
  output logic [19:0] x_move_right,
  output logic [19:0] y_move_right,
  output logic [19:0] x_move_down,
  output logic [19:0] y_move_down,
  output logic [19:0] x_rotate_left,
  output logic [19:0] y_rotate_left,
  output logic [19:0] x_rotate_right,
  output logic [19:0] y_rotate_right,
  output logic        get_new_block,
  output block_color  block,
  output logic        game_over
);

  localparam int CNT_W = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRAVITY_FRAMES - 1);

  // Reset piece is I, rot 0, at (SPAWN_X, 0): occupies row 1, columns SPAWN_X..+3.
  localparam logic [19:0] RST_X = {SPAWN_X, SPAWN_X + 5'd1, SPAWN_X + 5'd2, SPAWN_X + 5'd3};
  localparam logic [19:0] RST_Y = {5'd1, 5'd1, 5'd1, 5'd1};

  pc_state_e        state, state_n;
  logic [2:0]       ptype, ptype_n;
  logic [1:0]       rot, rot_n;
  logic [4:0]       ox, ox_n, oy, oy_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       keys_prev;   // {rot_r, rot_l, left, right} at last frame edge
  logic [3:0]       keys_now, keys_rise;

  logic [1:0]       rot_cw, rot_ccw;
  logic [7:0]       xo_cur, yo_cur, xo_cw, yo_cw, xo_ccw, yo_ccw;

  // Origin plus 2-bit offsets, mod 32; a wrapped cell lands far outside the
  // board and is rejected by its bounds check.
  function automatic logic [19:0] place(input logic [4:0] org, input logic [7:0] off);
    return {org + {3'b0, off[7:6]}, org + {3'b0, off[5:4]},
            org + {3'b0, off[3:2]}, org + {3'b0, off[1:0]}};
  endfunction

  assign rot_cw  = rot + 2'd1;
  assign rot_ccw = rot - 2'd1;

  tetromino_shape u_shape_cur (.piece_type(ptype), .rot(rot),     .x_off(xo_cur), .y_off(yo_cur));
  tetromino_shape u_shape_cw  (.piece_type(ptype), .rot(rot_cw),  .x_off(xo_cw),  .y_off(yo_cw));
  tetromino_shape u_shape_ccw (.piece_type(ptype), .rot(rot_ccw), .x_off(xo_ccw), .y_off(yo_ccw));

  assign x_block        = place(ox, xo_cur);
  assign y_block        = place(oy, yo_cur);
  assign x_move_left    = place(ox - 5'd1, xo_cur);
  assign y_move_left    = y_block;
  assign x_move_right   = place(ox + 5'd1, xo_cur);
  assign y_move_right   = y_block;
  assign x_move_down    = x_block;
  assign y_move_down    = place(oy + 5'd1, yo_cur);
  assign x_rotate_right = place(ox, xo_cw);
  assign y_rotate_right = place(oy, yo_cw);
  assign x_rotate_left  = place(ox, xo_ccw);
  assign y_rotate_left  = place(oy, yo_ccw);

  assign keys_now  = {key_rot_r, key_rot_l, key_left, key_right};
  assign keys_rise = keys_now & ~keys_prev;

  always_comb begin
    state_n       = state;
    ptype_n       = ptype;
    rot_n         = rot;
    ox_n          = ox;
    oy_n          = oy;
    cnt_n         = cnt;
    get_new_block = 1'b0;
    game_over     = 1'b0;
    block         = type_color(ptype);
    case (state)
      WAIT_START: begin
        block = EMPTY;
        if (frame_clk_rising_edge) begin
          ptype_n = (rand_piece == 3'd7) ? 3'd0 : rand_piece;
          rot_n   = 2'd0;
          ox_n    = SPAWN_X;
          oy_n    = 5'd0;
          cnt_n   = '0;
          state_n = SPAWN;
        end
      end
      SPAWN: begin
        get_new_block = 1'b1;
        state_n       = FALL;
      end
      FALL: begin
        if (frame_clk_rising_edge && !BOARD_BUSY) begin
          if (key_down || cnt == CNT_LAST) begin
            if (can_move[0]) begin
              oy_n  = oy + 5'd1;
              cnt_n = '0;
            end else if (oy != 5'd0) begin
              state_n = LOCK;
            end else begin
              state_n = OVER;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
            // Highest-priority new press wins; if it is illegal, nothing moves.
            if (keys_rise[3]) begin
              if (can_move[2]) rot_n = rot + 2'd1;
            end else if (keys_rise[2]) begin
              if (can_move[1]) rot_n = rot - 2'd1;
            end else if (keys_rise[1]) begin
              if (can_move[4]) ox_n = ox - 5'd1;
            end else if (keys_rise[0]) begin
              if (can_move[3]) ox_n = ox + 5'd1;
            end
          end
        end
      end
      LOCK: begin
        ptype_n = (rand_piece == 3'd7) ? 3'd0 : rand_piece;
        rot_n   = 2'd0;
        ox_n    = SPAWN_X;
        oy_n    = 5'd0;
        cnt_n   = '0;
        state_n = SPAWN;
      end
      OVER: begin
        game_over = 1'b1;
      end
      default: state_n = WAIT_START;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= WAIT_START;
      ptype <= 3'd0;
      rot   <= 2'd0;
      ox    <= SPAWN_X;
      oy    <= 5'd0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptype <= ptype_n;
      rot   <= rot_n;
      ox    <= ox_n;
      oy    <= oy_n;
      cnt   <= cnt_n;
    end
  end

  // Key levels are sampled only at frame edges; that is what defines a new press.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      keys_prev <= 4'b0;
    end else if (frame_clk_rising_edge) begin
      keys_prev <= keys_now;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      save_xblock <= RST_X;
      save_yblock <= RST_Y;
    end else begin
      save_xblock <= x_block;
      save_yblock <= y_block;
    end
  end

endmodule

// File: tb/tb_piece_controller.sv
// Directed bench for piece_controller: spawn, gravity, key edges, busy freeze,
// lock/respawn, game over and asynchronous reset.
module tb_piece_controller;
  import piece_controller_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk_rising_edge;
  logic        key_left, key_right, key_rot_l, key_rot_r, key_down;
  logic [4:0]  can_move;
  logic        BOARD_BUSY;
  logic [2:0]  rand_piece;
  logic [19:0] x_block, y_block, save_xblock, save_yblock;
  logic [19:0] x_move_left, y_move_left, x_move_right, y_move_right;
  logic [19:0] x_move_down, y_move_down, x_rotate_left, y_rotate_left;
  logic [19:0] x_rotate_right, y_rotate_right;
  logic        get_new_block, game_over;
  block_color  block;

  int n_checks = 0;
  int n_errors = 0;

  piece_controller dut (
    .Clk(Clk), .Reset(Reset), .frame_clk_rising_edge(frame_clk_rising_edge),
    .key_left(key_left), .key_right(key_right), .key_rot_l(key_rot_l),
    .key_rot_r(key_rot_r), .key_down(key_down), .can_move(can_move),
    .BOARD_BUSY(BOARD_BUSY), .rand_piece(rand_piece),
    .x_block(x_block), .y_block(y_block),
    .save_xblock(save_xblock), .save_yblock(save_yblock),
    .x_move_left(x_move_left), .y_move_left(y_move_left),
    .x_move_right(x_move_right), .y_move_right(y_move_right),
    .x_move_down(x_move_down), .y_move_down(y_move_down),
    .x_rotate_left(x_rotate_left), .y_rotate_left(y_rotate_left),
    .x_rotate_right(x_rotate_right), .y_rotate_right(y_rotate_right),
    .get_new_block(get_new_block), .block(block), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    return {a[4:0], b[4:0], c[4:0], d[4:0]};
  endfunction

  task automatic clk1();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame();
    @(posedge Clk);
    #1 frame_clk_rising_edge = 1'b1;
    @(posedge Clk);
    #1 frame_clk_rising_edge = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  initial begin
    Reset = 1'b1;
    frame_clk_rising_edge = 1'b0;
    {key_left, key_right, key_rot_l, key_rot_r, key_down} = 5'b0;
    can_move   = 5'b11111;
    BOARD_BUSY = 1'b0;
    rand_piece = 3'd2;
    repeat (3) clk1();

    // Reset state
    check("rst_gnb", get_new_block, 1'b0);
    check("rst_over", game_over, 1'b0);
    check("rst_block", block, EMPTY);
    check("rst_x", x_block, pk(3, 4, 5, 6));
    check("rst_y", y_block, pk(1, 1, 1, 1));
    check("rst_save_x", save_xblock, pk(3, 4, 5, 6));
    check("rst_save_y", save_yblock, pk(1, 1, 1, 1));
    Reset = 1'b0;
    clk1();
    check("idle_block", block, EMPTY);

    // Spawn T
    frame();
    check("spawn_gnb", get_new_block, 1'b1);
    check("spawn_x", x_block, pk(4, 3, 4, 5));
    check("spawn_y", y_block, pk(0, 1, 1, 1));
    check("spawn_color", block, PURPLE);
    clk1();
    check("fall_gnb", get_new_block, 1'b0);

    // Gravity after 30 frame edges
    frames(29);
    check("grav29_y", y_block, pk(0, 1, 1, 1));
    frame();
    check("grav30_y", y_block, pk(1, 2, 2, 2));
    check("grav30_save_y", save_yblock, pk(0, 1, 1, 1));
    clk1();
    check("grav_save_y", save_yblock, pk(1, 2, 2, 2));
    check("grav_save_x", save_xblock, pk(4, 3, 4, 5));
    check("cand_left_x", x_move_left, pk(3, 2, 3, 4));
    check("cand_right_x", x_move_right, pk(5, 4, 5, 6));
    check("cand_down_y", y_move_down, pk(2, 3, 3, 3));
    check("cand_rr_x", x_rotate_right, pk(4, 4, 5, 4));
    check("cand_rr_y", y_rotate_right, pk(1, 2, 2, 3));
    check("cand_rl_x", x_rotate_left, pk(4, 3, 4, 4));
    check("cand_rl_y", y_rotate_left, pk(1, 2, 2, 3));

    // Held left moves once; blocked left does nothing
    key_left = 1'b1;
    frames(3);
    check("left_once_x", x_block, pk(3, 2, 3, 4));
    key_left = 1'b0;
    frame();
    can_move = 5'b01111;
    key_left = 1'b1;
    frame();
    check("left_blocked_x", x_block, pk(3, 2, 3, 4));
    key_left = 1'b0;
    can_move = 5'b11111;
    frame();

    // rot_r beats left
    key_rot_r = 1'b1;
    key_left  = 1'b1;
    frame();
    check("prio_x", x_block, pk(3, 3, 4, 3));
    check("prio_y", y_block, pk(1, 2, 2, 3));
    key_rot_r = 1'b0;
    key_left  = 1'b0;
    frame();   // counter now 8

    // Board busy freezes everything, including the gravity counter
    BOARD_BUSY = 1'b1;
    frames(40);
    check("busy_y", y_block, pk(1, 2, 2, 3));
    check("busy_x", x_block, pk(3, 3, 4, 3));
    BOARD_BUSY = 1'b0;
    frames(21);
    check("resume_hold_y", y_block, pk(1, 2, 2, 3));
    frame();
    check("resume_drop_y", y_block, pk(2, 3, 3, 4));

    // Soft drop down to oy = 7
    key_down = 1'b1;
    frames(5);
    check("soft_y", y_block, pk(7, 8, 8, 9));

    // Blocked drop locks, next piece is I (rand 7 maps to 0)
    can_move   = 5'b11110;
    rand_piece = 3'd7;
    frame();
    check("lock_gnb", get_new_block, 1'b0);
    check("lock_x", x_block, pk(3, 3, 4, 3));
    clk1();
    check("respawn_gnb", get_new_block, 1'b1);
    check("respawn_x", x_block, pk(3, 4, 5, 6));
    check("respawn_y", y_block, pk(1, 1, 1, 1));
    check("respawn_save_x", save_xblock, pk(3, 3, 4, 3));
    check("respawn_save_y", save_yblock, pk(7, 8, 8, 9));
    check("respawn_color", block, CYAN);

    // Blocked drop at oy = 0 ends the game
    frame();
    check("over_flag", game_over, 1'b1);
    check("over_gnb", get_new_block, 1'b0);
    frames(2);
    check("over_hold_gnb", get_new_block, 1'b0);
    check("over_hold_flag", game_over, 1'b1);
    check("over_hold_y", y_block, pk(1, 1, 1, 1));
    key_down = 1'b0;
    can_move = 5'b11111;
    Reset = 1'b1;
    #2;
    check("over_reset_flag", game_over, 1'b0);
    check("over_reset_block", block, EMPTY);
    clk1();
    Reset = 1'b0;

    // Reset mid-fall abandons the piece
    rand_piece = 3'd4;
    frame();
    check("z_spawn_x", x_block, pk(3, 4, 4, 5));
    check("z_spawn_y", y_block, pk(0, 0, 1, 1));
    check("z_color", block, RED);
    key_right = 1'b1;
    frame();
    check("z_right_x", x_block, pk(4, 5, 5, 6));
    key_right = 1'b0;
    Reset = 1'b1;
    #2;
    check("midrst_x", x_block, pk(3, 4, 5, 6));
    check("midrst_gnb", get_new_block, 1'b0);
    clk1();
    Reset = 1'b0;
    repeat (3) clk1();
    check("postrst_gnb", get_new_block, 1'b0);
    check("postrst_save_x", save_xblock, pk(3, 4, 5, 6));
    check("postrst_block", block, EMPTY);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/piece_controller.md
PIECE_CONTROLLER -- requirements
Module: piece_controller

Interface
REQ-001 The block SHALL use one clock, Clk, and reset, Reset; Reset is asynchronous and active-high.
REQ-002 Parameter GRAVITY_FRAMES, default 30: frame edges between gravity drop attempts.
REQ-003 Parameter SPAWN_X, default 5'd3: x origin of a new piece; the spawn y origin is 0.
REQ-004 Ports: Clk  in  1  system clock; Reset  in  1  async active-high reset.
REQ-005 Ports: frame_clk_rising_edge  in  1  one-Clk pulse per video frame.
REQ-006 Ports: key_left, key_right, key_rot_l, key_rot_r, key_down  in  1 each  level key states.
REQ-007 Ports: can_move  in  5  legality of each candidate move: [4] left, [3] right, [2] rotate right, [1] rotate left, [0] down.
REQ-008 Ports: BOARD_BUSY  in  1  board is clearing or dropping rows; rand_piece  in  3  piece select.
REQ-009 Ports: x_block, y_block  out  20  current piece cells, packed cell0..cell3 as [19:15],[14:10],[9:5],[4:0].
REQ-010 Ports: save_xblock, save_yblock  out  20  cells drawn on the previous Clk, same packing.
REQ-011 Ports: x_/y_move_left, x_/y_move_right, x_/y_move_down, x_/y_rotate_left, x_/y_rotate_right  out  20 each  candidate cells.
REQ-012 Ports: get_new_block  out  1  spawn pulse; block  out  block_color  piece colour; game_over  out  1.

Function
REQ-013 Piece state SHALL be: type (3b), rot (2b), origin ox, oy (5b each); cell = origin + shape offset, 5-bit mod-32 arithmetic, so an underflow wraps to a value of at least 10 and is rejected by the board's bounds check.
REQ-014 Shapes SHALL follow SRS orientations in a 4x4 box: type 0..6 = I,O,T,S,Z,J,L; I rot0 = (0,1),(1,1),(2,1),(3,1); T rot0 = (1,0),(0,1),(1,1),(2,1); O is identical for all rot.
REQ-015 The candidate outputs SHALL be combinational from piece state, each with one change: left ox-1; right ox+1; down oy+1; rotate right rot+1 mod 4; rotate left rot-1 mod 4.
REQ-016 save_xblock/save_yblock SHALL register x_block/y_block on every Clk.
REQ-017 The FSM SHALL have states WAIT_START, SPAWN, FALL, LOCK, OVER.
REQ-018 WAIT_START: block=EMPTY; on frame_clk_rising_edge, load a new piece and go to SPAWN.
REQ-019 A new-piece load SHALL set: type = rand_piece, with 7 mapped to 0; rot = 0; ox = SPAWN_X; oy = 0; gravity counter = 0.
REQ-020 SPAWN SHALL last exactly one Clk, with get_new_block=1, then go to FALL; get_new_block SHALL be 0 in every other state.
REQ-021 FALL SHALL act only on a frame_clk_rising_edge with BOARD_BUSY=0; otherwise all state holds and the gravity counter does not advance.
REQ-022 In FALL, a drop is due when key_down=1 or the gravity counter = GRAVITY_FRAMES-1; otherwise the counter increments.
REQ-023 A due drop SHALL take priority over keys: if can_move[0]=1, oy+1 and counter = 0; if can_move[0]=0, go to LOCK when oy != 0, or to OVER when oy = 0.
REQ-024 With no drop due, at most one key action SHALL apply per frame edge, priority rot_r > rot_l > left > right.
REQ-025 A key action SHALL apply only when the key is 1 at this frame edge, was 0 at the previous frame edge, and its can_move bit is 1; a blocked key is discarded.
REQ-026 LOCK SHALL last one Clk, load a new piece, and go to SPAWN; x_block then equals the new spawn cells while save_* still hold the locked cells.
REQ-027 OVER: game_over=1; piece state frozen; no pulses until Reset.
REQ-028 block SHALL be the type's colour from the shared package in every state except WAIT_START.

Reset
REQ-029 Reset SHALL force: state WAIT_START; type 0, rot 0, ox SPAWN_X, oy 0; gravity counter 0; key history 0.
REQ-030 Reset SHALL force save_* equal to the reset x_block/y_block: x = {3,4,5,6}, y = {1,1,1,1}.
REQ-031 During reset: get_new_block=0, game_over=0, block=EMPTY; reset mid-fall SHALL abandon the piece with no pulse.

Structure
REQ-032 The piece type encoding, the colour-per-type function, GRAVITY_FRAMES and SPAWN_X defaults SHALL live in the shared types package, beside block_color.
REQ-033 The SRS table SHALL be sub-module tetromino_shape (type, rot -> 4 x and 4 y 2-bit offsets), instantiated three times: rot, rot+1, rot-1.

Verification
REQ-034 Reset, one frame edge, rand_piece=2 -> one-Clk get_new_block; x_block={4,3,4,5}, y_block={0,1,1,1}.
REQ-035 T spawned, can_move=5'b11111, 30 frame edges, no keys -> y_block={1,2,2,2} after the 30th edge; save_* follow one Clk later.
REQ-036 key_left held 3 frames, can_move[4]=1 -> ox decrements once only; with can_move[4]=0 -> no change.
REQ-037 Drop due, can_move[0]=0, oy=7 -> LOCK, then SPAWN with get_new_block=1; save_* hold the locked cells.
REQ-038 BOARD_BUSY=1 across 40 frame edges -> no motion and the counter is frozen; motion resumes on release.
REQ-039 Drop blocked at oy=0 -> game_over=1, get_new_block stays 0; Reset clears game_over.
